// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle CPU controller: states, opcodes,
// datapath mux codes and the bundled control word.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_AND  = 7'd2;
  localparam logic [6:0] OP_OR   = 7'd3;
  localparam logic [6:0] OP_ADDI = 7'd4;
  localparam logic [6:0] OP_LW   = 7'd5;
  localparam logic [6:0] OP_SW   = 7'd6;
  localparam logic [6:0] OP_BEQ  = 7'd7;
  localparam logic [6:0] OP_BNE  = 7'd8;
  localparam logic [6:0] OP_J    = 7'd9;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_IMM    = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_outputs.sv
// Combinational state-to-control decode; write strobes are masked by
// enable and by reset so an abort takes effect without waiting for a clock.
module controller_outputs
  import multicycle_controller_pkg::*;
#(
  parameter logic [1:0] PC_INC_SEL = SRCB_ONE
) (
  input  state_e     state_i,
  input  logic       bne_i,
  input  logic       alu_zero_i,
  input  logic       enable_i,
  input  logic       rst_i,
  input  logic [1:0] rop_i,
  output ctrl_t      ctrl_o
);

  ctrl_t raw;

  always_comb begin
    raw = '0;
    case (state_i)
      S_FETCH: begin
        raw.ir_write  = 1'b1;
        raw.alu_src_b = PC_INC_SEL;
        raw.alu_op    = ALU_ADD;
        raw.pc_source = PCS_ALU;
        raw.pc_write  = 1'b1;
      end
      S_DECODE: begin
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_REG;
        raw.alu_op    = {2'b00, rop_i};
      end
      S_EXEC_I, S_MEM_ADDR: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = ALU_ADD;
      end
      S_WB_ALU: raw.reg_write = 1'b1;
      S_MEM_RD: raw.iord = 1'b1;
      S_WB_MEM: begin
        raw.reg_write  = 1'b1;
        raw.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        raw.iord      = 1'b1;
        raw.mem_write = 1'b1;
      end
      S_BRANCH: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_REG;
        raw.alu_op    = ALU_SUB;
        raw.pc_source = PCS_ALUOUT;
        raw.pc_write  = bne_i ? ~alu_zero_i : alu_zero_i;
      end
      S_JUMP: begin
        raw.pc_source = PCS_IMM;
        raw.pc_write  = 1'b1;
      end
      default: ;
    endcase

    ctrl_o = raw;
    // Mux selects keep their state values during a stall; only strobes drop.
    if (!enable_i || rst_i) begin
      ctrl_o.pc_write  = 1'b0;
      ctrl_o.ir_write  = 1'b0;
      ctrl_o.mem_write = 1'b0;
      ctrl_o.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: state register, next-state logic and the
// sticky halted/illegal status; control decode lives in controller_outputs.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter logic [6:0] HALT_OP    = 7'h7F,
  parameter logic [1:0] PC_INC_SEL = 2'd1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       enable,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_e     state_q, state_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  // Branch flavour and R-type ALU op are captured in DECODE so later
  // opcode changes cannot disturb the instruction in flight.
  logic       bne_q, bne_d;
  logic [1:0] rop_q, rop_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    bne_d     = bne_q;
    rop_d     = rop_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        bne_d = (opcode == OP_BNE);
        rop_d = opcode[1:0];
        if (opcode == HALT_OP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
            OP_ADDI:                       state_d = S_EXEC_I;
            OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                state_d = S_BRANCH;
            OP_J:                          state_d = S_JUMP;
            default: begin
              state_d   = S_HALT;
              halted_d  = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR:         state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:           state_d = S_WB_MEM;
      S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:             state_d = S_HALT;
      default:            state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bne_q     <= 1'b0;
      rop_q     <= 2'b00;
    end else if (enable) begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      bne_q     <= bne_d;
      rop_q     <= rop_d;
    end
  end

  controller_outputs #(.PC_INC_SEL(PC_INC_SEL)) u_outputs (
    .state_i    (state_q),
    .bne_i      (bne_q),
    .alu_zero_i (alu_zero),
    .enable_i   (enable),
    .rst_i      (Reset),
    .rop_i      (rop_q),
    .ctrl_o     (ctrl)
  );

  assign PCWrite   = ctrl.pc_write;
  assign IRWrite   = ctrl.ir_write;
  assign MemWrite  = ctrl.mem_write;
  assign RegWrite  = ctrl.reg_write;
  assign IorD      = ctrl.iord;
  assign MemToReg  = ctrl.mem_to_reg;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign PCSource  = ctrl.pc_source;
  assign ALUOp     = ctrl.alu_op;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule
